// File: rtl/bram_wb_bridge.sv
// bram_wb_bridge: Wishbone B3 slave front-end for the generic_sync_mem block RAM.
// Translates bus cycles into RAM strobes, acks one cycle later (registered),
// and emulates byte-lane writes with a read-modify-write sequence.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   wb_cyc_i/stb_i/we_i, wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i
//                      Wishbone slave inputs
//   wb_dat_o, wb_ack_o Wishbone slave outputs (data is RAM output, ack is registered)
//   mem_address, mem_data_in, mem_cs, mem_we, mem_data_out
//                      RAM-side strobes and read data
//
// Build option: define BRAM_WB_BURST_EN to enable incrementing-burst reads
// (wb_cti_i = 3'b010) at one word per cycle. Without it wb_cti_i is ignored.

module bram_wb_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic [SEL_WIDTH-1:0]  wb_sel_i,
    input  logic [2:0]            wb_cti_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_cs,
    output logic                  mem_we
);

`ifdef BRAM_WB_BURST_EN
    typedef enum logic [1:0] {IDLE, RMW, ACK, BURST} state_t;
`else
    typedef enum logic [1:0] {IDLE, RMW, ACK} state_t;
`endif

    state_t state, state_nxt;
    logic   ack_nxt;
    logic   req;
    logic [DATA_WIDTH-1:0] merged;

    assign req      = wb_cyc_i & wb_stb_i;
    assign wb_dat_o = mem_data_out;

    // Byte-lane merge for the write half of a read-modify-write:
    // selected lanes come from the bus, the rest from the word just read.
    always_comb begin
        merged = mem_data_out;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            if (wb_sel_i[k]) begin
                merged[8*k +: 8] = wb_dat_i[8*k +: 8];
            end
        end
    end

`ifdef BRAM_WB_BURST_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] next_addr, next_addr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_addr <= '0;
        end else begin
            next_addr <= next_addr_nxt;
        end
    end
`else
    // Cycle type only matters for bursts; reduce it to a dummy sink.
    logic unused_cti;
    assign unused_cti = ^wb_cti_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_ack_o <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ack_nxt     = 1'b0;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_address = wb_adr_i;
        mem_data_in = wb_dat_i;
`ifdef BRAM_WB_BURST_EN
        next_addr_nxt = next_addr;
`endif
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!wb_we_i) begin
                        mem_cs    = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = ACK;
`ifdef BRAM_WB_BURST_EN
                        if (wb_cti_i == 3'b010) begin
                            state_nxt     = BURST;
                            next_addr_nxt = wb_adr_i + ADDR_ONE;
                        end
`endif
                    end else if (&wb_sel_i) begin
                        mem_cs    = 1'b1;
                        mem_we    = 1'b1;
                        ack_nxt   = 1'b1;
                        state_nxt = ACK;
                    end else if (wb_sel_i == '0) begin
                        // Nothing to write: ack without touching the RAM.
                        ack_nxt   = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        mem_cs    = 1'b1;
                        state_nxt = RMW;
                    end
                end
            end
            RMW: begin
                if (wb_cyc_i) begin
                    mem_cs      = 1'b1;
                    mem_we      = 1'b1;
                    mem_data_in = merged;
                    ack_nxt     = 1'b1;
                    state_nxt   = ACK;
                end else begin
                    // Master abandoned the cycle: drop the write silently.
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
`ifdef BRAM_WB_BURST_EN
            BURST: begin
                // Ack is high here; each continuing beat prefetches the next word.
                if (req && wb_cti_i != 3'b111) begin
                    mem_cs        = 1'b1;
                    mem_address   = next_addr;
                    next_addr_nxt = next_addr + ADDR_ONE;
                    ack_nxt       = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Keep the RAM quiet while reset is held, whatever the bus does.
        if (rst) begin
            mem_cs = 1'b0;
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_bram_wb_bridge.sv
// tb_bram_wb_bridge: self-checking bench for bram_wb_bridge with a behavioural
// synchronous RAM, a reference memory model and a read-data scoreboard.

module tb_bram_wb_bridge;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [SW-1:0] sel;
    logic [2:0]    cti;
    logic [DW-1:0] dat_r;
    logic          ack;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_cs, mem_we;

    int checks = 0;
    int errors = 0;
    int cs_cnt = 0;
    int we_cnt = 0;

    logic [DW-1:0] ram   [0:255];
    logic [DW-1:0] model [0:255];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    bram_wb_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_we_i      (we),
        .wb_adr_i     (adr),
        .wb_dat_i     (dat_w),
        .wb_sel_i     (sel),
        .wb_cti_i     (cti),
        .wb_dat_o     (dat_r),
        .wb_ack_o     (ack),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_cs       (mem_cs),
        .mem_we       (mem_we)
    );

    // Synchronous RAM with registered, read-before-write output.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_address] <= mem_data_in;
            mem_data_out <= ram[mem_address];
        end
    end

    always @(negedge clk) begin
        if (mem_cs === 1'b1) cs_cnt++;
        if (mem_we === 1'b1) we_cnt++;
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = old_w;
        for (int k = 0; k < SW; k++)
            if (s[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    // One classic transfer; lat = cycles from strobe to ack, -1 on timeout.
    task automatic bus_xfer(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s,
                            output int lat, output logic [DW-1:0] rd);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        cti = 3'b000;
        lat = -1;
        rd  = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                lat = k;
                rd  = dat_r;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output int lat);
        logic [DW-1:0] rd;
        bus_xfer(1'b1, a, d, s, lat, rd);
        if (lat >= 0) model[a] = merge(model[a], d, s);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int lat,
                           output logic [DW-1:0] rd);
        exp_q.push_back(model[a]);
        bus_xfer(1'b0, a, '0, '0, lat, rd);
    endtask

    task automatic check_read(input string name, input int lat,
                              input logic [DW-1:0] rd);
        logic [DW-1:0] e;
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL %s_lat: got %0d want 1", name, lat);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_data: scoreboard empty, got %h", name, rd);
        end else begin
            e = exp_q.pop_front();
            if (rd !== e) begin
                errors++;
                $display("FAIL %s_data: got %h want %h", name, rd, e);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = '1;
        adr = 8'h01; dat_w = 32'h5555_5555; cti = 3'b000;
        repeat (2) @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack: got %b want 0", ack);
        end
        checks++;
        if (mem_cs !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: cs=%b we=%b want 0 0", mem_cs, mem_we);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_write;
        int lat, w0;
        logic [DW-1:0] rd;
        w0 = we_cnt;
        do_write(8'h10, 32'hDEAD_BEEF, 4'hF, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL full_wr_lat: got %0d want 1", lat);
        end
        checks++;
        if (we_cnt - w0 !== 1) begin
            errors++; $display("FAIL full_wr_we: got %0d want 1", we_cnt - w0);
        end
        do_read(8'h10, lat, rd);
        check_read("full_rd", lat, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL full_rd_const: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_partial_write;
        int lat, w0, c0;
        logic [DW-1:0] rd;
        do_write(8'h20, 32'h1122_3344, 4'hF, lat);
        w0 = we_cnt;
        c0 = cs_cnt;
        do_write(8'h20, 32'hAABB_CCDD, 4'b0101, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL part_wr_lat: got %0d want 2", lat);
        end
        checks++;
        if (we_cnt - w0 !== 1 || cs_cnt - c0 !== 2) begin
            errors++;
            $display("FAIL part_wr_strobes: we=%0d cs=%0d want 1 2",
                     we_cnt - w0, cs_cnt - c0);
        end
        do_read(8'h20, lat, rd);
        check_read("part_rd", lat, rd);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            errors++; $display("FAIL part_rd_const: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_sel_zero;
        int lat, c0;
        logic [DW-1:0] rd;
        do_write(8'h30, 32'h1234_5678, 4'hF, lat);
        c0 = cs_cnt;
        do_write(8'h30, 32'hFFFF_FFFF, 4'h0, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL sel0_lat: got %0d want 1", lat);
        end
        checks++;
        if (cs_cnt - c0 !== 0) begin
            errors++; $display("FAIL sel0_cs: got %0d want 0", cs_cnt - c0);
        end
        do_read(8'h30, lat, rd);
        check_read("sel0_rd", lat, rd);
    endtask

    task automatic test_rmw_abort;
        int lat, w0, acks;
        logic [DW-1:0] rd;
        do_write(8'h40, 32'hCAFE_F00D, 4'hF, lat);
        w0 = we_cnt;
        acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h40;
        dat_w = 32'h0000_0000; sel = 4'b0011;
        @(negedge clk);
        if (ack === 1'b1) acks++;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        we = 1'b0; sel = '0;
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL abort_ack: got %0d acks want 0", acks);
        end
        checks++;
        if (we_cnt - w0 !== 0) begin
            errors++; $display("FAIL abort_we: got %0d want 0", we_cnt - w0);
        end
        do_read(8'h40, lat, rd);
        check_read("abort_rd", lat, rd);
    endtask

    task automatic test_rst_mid_rmw;
        int lat, w0;
        logic [DW-1:0] rd;
        do_write(8'h50, 32'h0BAD_F00D, 4'hF, lat);
        w0 = we_cnt;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h50;
        dat_w = 32'hFFFF_FFFF; sel = 4'b1000;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0 || mem_cs !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw: ack=%b cs=%b we=%b want 0 0 0",
                     ack, mem_cs, mem_we);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (we_cnt - w0 !== 0) begin
            errors++; $display("FAIL rst_rmw_we: got %0d want 0", we_cnt - w0);
        end
        do_read(8'h50, lat, rd);
        check_read("rst_rmw_rd", lat, rd);
    endtask

    task automatic test_back_to_back;
        int c0;
        logic [3:0] pat;
        logic [DW-1:0] e;
        c0 = cs_cnt;
        exp_q.push_back(model[8'h10]);
        exp_q.push_back(model[8'h10]);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10; sel = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[k] = ack;
            if (ack === 1'b1) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (dat_r !== e) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", k, dat_r, e);
                end
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (pat !== 4'b1010) begin
            errors++; $display("FAIL b2b_ack: got %b want 1010", pat);
        end
        checks++;
        if (cs_cnt - c0 !== 2) begin
            errors++; $display("FAIL b2b_cs: got %0d want 2", cs_cnt - c0);
        end
        exp_q.delete();
    endtask

`ifdef BRAM_WB_BURST_EN
    task automatic test_burst;
        int lat;
        logic [4:0] pat;
        logic [DW-1:0] e;
        do_write(8'hFE, 32'd1, 4'hF, lat);
        do_write(8'hFF, 32'd2, 4'hF, lat);
        do_write(8'h00, 32'd3, 4'hF, lat);
        exp_q.push_back(model[8'hFE]);
        exp_q.push_back(model[8'hFF]);
        exp_q.push_back(model[8'h00]);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'hFE; sel = '0;
        cti = 3'b010;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (k == 3) cti = 3'b111;
                if (k == 4) begin
                    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
                end
            end
            @(negedge clk);
            pat[k] = ack;
            if (ack === 1'b1) begin
                checks++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                if (dat_r !== e) begin
                    errors++;
                    $display("FAIL burst_data%0d: got %h want %h", k, dat_r, e);
                end
            end
        end
        checks++;
        if (pat !== 5'b01110) begin
            errors++; $display("FAIL burst_ack: got %b want 01110", pat);
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_write();
        test_partial_write();
        test_sel_zero();
        test_rmw_abort();
        test_rst_mid_rmw();
        test_back_to_back();
`ifdef BRAM_WB_BURST_EN
        test_burst();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
